atm_balance_arbiter: RTL and testbench

ATM_BALANCE_ARBITER -- requirements
Module: atm_balance_arbiter

---
 rtl/atm_pkg.sv | 19 +
 rtl/rr_pick.sv | 35 +++
 rtl/atm_balance_arbiter.sv | 133 +++++++++++++
 tb/tb_atm_balance_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared encodings and widths for the ATM balance arbiter.
package atm_pkg;

    localparam int BAL_W = 8;
    localparam int AMT_W = 6;

    localparam logic [1:0] OP_WD   = 2'd0;
    localparam logic [1:0] OP_DEP  = 2'd1;
    localparam logic [1:0] OP_CHK  = 2'd2;
    localparam logic [1:0] OP_EXIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select, combinational (zero latency); the first set req bit at or after rr_ptr wins.
// No backpressure; the winner is one-hot, or zero when no req bit is set.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner
);

    logic             found;
    logic [PTR_W-1:0] idx;
    int               pos;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        pos    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // Wrap by subtraction so N_REQ need not be a power of two.
            pos = int'(rr_ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            idx = PTR_W'(pos);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/atm_balance_arbiter.sv
// Shared-balance arbiter for N_REQ ATM terminals: IDLE->LATCH->EXEC->RESP, done 3 cycles after req is sampled.
// No backpressure; a terminal holds req level until granted, and the grant holds until the transaction completes.
module atm_balance_arbiter
    import atm_pkg::*;
#(
    parameter logic [7:0] INIT_BAL = 8'd100,
    parameter int         N_REQ    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   op,
    input  logic [6*N_REQ-1:0]   amt,
    output logic [N_REQ-1:0]     gnt,
    output logic                 done,
    output logic                 ok,
    output logic [7:0]           balance,
    output logic                 busy,
    output logic [7:0]           txn_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   pick;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [1:0]         op_win, op_q;
    logic [AMT_W-1:0]   amt_win, amt_q;
    logic [BAL_W-1:0]   amt_ext;
    logic [BAL_W:0]     dep_sum;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick)
    );

    // Slice selection and pointer advance follow the held grant, not live req.
    always_comb begin
        op_win  = '0;
        amt_win = '0;
        ptr_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                op_win  = op[2*i +: 2];
                amt_win = amt[AMT_W*i +: AMT_W];
                ptr_nxt = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign amt_ext = {{(BAL_W - AMT_W){1'b0}}, amt_q};
    assign dep_sum = {1'b0, balance} + {1'b0, amt_ext};
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|req) state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            balance <= INIT_BAL;
            gnt     <= '0;
            done    <= 1'b0;
            ok      <= 1'b0;
            txn_cnt <= '0;
            rr_ptr  <= '0;
            op_q    <= '0;
            amt_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) gnt <= pick;
                end
                ST_LATCH: begin
                    op_q  <= op_win;
                    amt_q <= amt_win;
                end
                // Results land on the EXEC->RESP edge so done/ok/balance are coherent in RESP.
                ST_EXEC: begin
                    done    <= 1'b1;
                    txn_cnt <= txn_cnt + 8'd1;
                    rr_ptr  <= ptr_nxt;
                    case (op_q)
                        OP_WD: begin
                            if (amt_ext <= balance) begin
                                balance <= balance - amt_ext;
                                ok      <= 1'b1;
                            end else begin
                                ok <= 1'b0;
                            end
                        end
                        OP_DEP: begin
                            if (!dep_sum[BAL_W]) begin
                                balance <= dep_sum[BAL_W-1:0];
                                ok      <= 1'b1;
                            end else begin
                                ok <= 1'b0;
                            end
                        end
                        OP_CHK:  ok <= 1'b1;
                        default: ok <= 1'b0;
                    endcase
                end
                ST_RESP: begin
                    gnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// Directed plus randomized bench for atm_balance_arbiter against an arithmetic account model.
module tb_atm_balance_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [23:0] amt;
    logic [3:0]  gnt;
    logic        done;
    logic        ok;
    logic [7:0]  balance;
    logic        busy;
    logic [7:0]  txn_cnt;

    atm_balance_arbiter #(
        .INIT_BAL (8'd100),
        .N_REQ    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .op      (op),
        .amt     (amt),
        .gnt     (gnt),
        .done    (done),
        .ok      (ok),
        .balance (balance),
        .busy    (busy),
        .txn_cnt (txn_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference account: plain integers.
    int m_bal;
    int m_cnt;
    int m_ptr;
    int m_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_exec(input int w, input int o, input int a);
        case (o)
            0: begin
                if (a <= m_bal) begin m_bal = m_bal - a; m_ok = 1; end
                else m_ok = 0;
            end
            1: begin
                if (m_bal + a <= 255) begin m_bal = m_bal + a; m_ok = 1; end
                else m_ok = 0;
            end
            2: m_ok = 1;
            default: m_ok = 0;
        endcase
        m_cnt = (m_cnt + 1) % 256;
        m_ptr = (w + 1) % 4;
    endtask

    // Called #1 after a posedge; leaves rst high across one more edge.
    task automatic reset_dut();
        req = '0;
        op  = '0;
        amt = '0;
        rst = 1'b1;
        #2;
        chk("rst_balance", balance, 100);
        chk("rst_txn_cnt", txn_cnt, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_ok", ok, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_bal = 100;
        m_cnt = 0;
        m_ptr = 0;
        m_ok  = 0;
    endtask

    // Starts in IDLE (#1 after a posedge) and returns in IDLE four edges later.
    task automatic run_txn(input logic [3:0] r, input logic [7:0] o, input logic [23:0] a,
                           input bit drop, input bit scramble);
        int w;
        int wo;
        int wa;
        w  = model_pick(r);
        wo = int'((o >> (2 * w)) & 8'd3);
        wa = int'((a >> (6 * w)) & 24'd63);
        req = r;
        op  = o;
        amt = a;
        @(posedge clk); #1;
        chk("latch_gnt", gnt, 32'(1 << w));
        chk("latch_busy", busy, 1);
        chk("latch_done", done, 0);
        @(posedge clk); #1;
        chk("exec_done", done, 0);
        chk("exec_gnt", gnt, 32'(1 << w));
        if (drop) req = '0;
        if (scramble) begin
            req = 4'($urandom);
            op  = 8'($urandom);
            amt = 24'($urandom);
        end
        model_exec(w, wo, wa);
        @(posedge clk); #1;
        chk("resp_done", done, 1);
        chk("resp_ok", ok, 32'(m_ok));
        chk("resp_balance", balance, 32'(m_bal));
        chk("resp_txn_cnt", txn_cnt, 32'(m_cnt));
        chk("resp_gnt", gnt, 32'(1 << w));
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("idle_gnt", gnt, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ok_hold", ok, 32'(m_ok));
    endtask

    task automatic idle_hold(input int cycles);
        req = '0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            chk("hold_busy", busy, 0);
            chk("hold_done", done, 0);
            chk("hold_balance", balance, 32'(m_bal));
            chk("hold_txn_cnt", txn_cnt, 32'(m_cnt));
            chk("hold_ok", ok, 32'(m_ok));
        end
    endtask

    initial begin
        reset_dut();

        // Withdraw 30 from 100 on terminal 0.
        run_txn(4'b0001, 8'h00, 24'd30, 1'b0, 1'b0);
        chk("s1_balance", balance, 70);
        chk("s1_txn_cnt", txn_cnt, 1);
        idle_hold(3);

        // Terminal 1: withdraw 63 succeeds, withdraw 8 from 7 fails.
        run_txn(4'b0010, 8'h00, 24'(63 << 6), 1'b0, 1'b0);
        chk("s2a_balance", balance, 7);
        run_txn(4'b0010, 8'h00, 24'(8 << 6), 1'b0, 1'b0);
        chk("s2b_ok", ok, 0);
        chk("s2b_balance", balance, 7);

        // Deposit up to 250 on terminal 2, then probe the 255 ceiling.
        for (int g = 0; g < 8 && m_bal < 250; g++) begin
            run_txn(4'b0100, 8'(1 << 4), 24'(((250 - m_bal) > 63 ? 63 : (250 - m_bal)) << 12), 1'b0, 1'b0);
        end
        chk("s3_pre_balance", balance, 250);
        run_txn(4'b0100, 8'(1 << 4), 24'(10 << 12), 1'b0, 1'b0);
        chk("s3_ovf_ok", ok, 0);
        chk("s3_ovf_balance", balance, 250);
        run_txn(4'b0100, 8'(1 << 4), 24'(5 << 12), 1'b0, 1'b0);
        chk("s3_max_ok", ok, 1);
        chk("s3_max_balance", balance, 255);

        // All four request checks continuously; rotation from pointer 0.
        reset_dut();
        for (int t = 0; t < 5; t++) begin
            run_txn(4'b1111, 8'hAA, 24'h0, 1'b0, 1'b0);
            chk("s4_ok", ok, 1);
            chk("s4_balance", balance, 100);
        end

        // Requester drops req in EXEC during withdraw of 20.
        reset_dut();
        run_txn(4'b0001, 8'h00, 24'd20, 1'b1, 1'b0);
        chk("s5_balance", balance, 80);
        chk("s5_txn_cnt", txn_cnt, 1);

        // Reset during EXEC of a withdraw of 50 aborts it.
        reset_dut();
        req = 4'b0001;
        op  = 8'h00;
        amt = 24'd50;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("s6_in_exec_busy", busy, 1);
        reset_dut();
        chk("s6_balance", balance, 100);
        chk("s6_busy", busy, 0);
        chk("s6_txn_cnt", txn_cnt, 0);
        idle_hold(4);

        // Random traffic with late input changes and drops.
        for (int n = 0; n < 60; n++) begin
            run_txn(4'($urandom_range(1, 15)), 8'($urandom), 24'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (n % 15 == 14) idle_hold(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
